pipeline_ctrl: RTL and testbench

Central hazard and stall sequencer for the 5-stage CPU (FE, DE, EX, MEM, WB). It owns the `hold` and `clear` controls of the four inter-stage pipeline registers (FE/DE, DE/EX, EX/MEM, MEM/WB) and the PC hold. It resolves memory wait states, multi-cycle EX operations, taken branches, load-use hazards and interrupt entry into one consistent set of controls per cycle. It is purely a control block and carries no datapath.

---
 rtl/cpu_ctrl_pkg.sv | 28 ++
 rtl/cycle_counter.sv | 38 +++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control blocks: FSM states, pipeline
// register indices and the control bundle driven to the datapath.
package cpu_ctrl_pkg;

   localparam int CNT_W = 4;

   // Inter-stage pipeline register indices
   localparam int STG_FEDE  = 0;
   localparam int STG_DEEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;
   localparam int NUM_STG   = 4;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MULDIV,
      ST_DRAIN,
      ST_JUMP
   } state_e;

   typedef struct packed {
      logic               hold_pc;
      logic [NUM_STG-1:0] hold;
      logic [NUM_STG-1:0] clear;
      logic               int_jump;
   } ctrl_t;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down counter that saturates at zero; shared by the MULDIV and DRAIN
// sequences of pipeline_ctrl.
module cycle_counter
   import cpu_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: turns memory waits,
// multi-cycle ops, branches, load-use hazards and interrupt entry into holds/clears.
module pipeline_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int DRAIN_CYCLES  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_busy,
   input  logic ex_multicycle,
   input  logic branch_taken,
   input  logic load_use,
   input  logic irq,
   input  logic reti,
   output logic hold_pc,
   output logic hold_fede,
   output logic hold_deex,
   output logic hold_exmem,
   output logic hold_memwb,
   output logic clear_fede,
   output logic clear_deex,
   output logic clear_exmem,
   output logic clear_memwb,
   output logic int_jump,
   output logic irq_ack,
   output logic int_active
);

   localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_e           state_q, state_d;
   logic             int_active_q, int_active_d;
   ctrl_t            ctrl;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;

   cycle_counter u_cycle_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .count    (cnt_val),
      .zero     (cnt_zero)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      ctrl         = '0;
      state_d      = state_q;
      int_active_d = reti ? 1'b0 : int_active_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      if (reset) begin
         ctrl.hold_pc = 1'b1;
         ctrl.clear   = '1;
         state_d      = ST_RUN;
         int_active_d = 1'b0;
      end else if (mem_busy) begin
         // EX is frozen: counters and state wait, MEM/WB gets a bubble
         ctrl.hold_pc              = 1'b1;
         ctrl.hold[STG_FEDE]       = 1'b1;
         ctrl.hold[STG_DEEX]       = 1'b1;
         ctrl.hold[STG_EXMEM]      = 1'b1;
         ctrl.clear[STG_MEMWB]     = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (ex_multicycle) begin
                  ctrl.hold_pc          = 1'b1;
                  ctrl.hold[STG_FEDE]   = 1'b1;
                  ctrl.hold[STG_DEEX]   = 1'b1;
                  ctrl.clear[STG_EXMEM] = 1'b1;
                  cnt_load              = 1'b1;
                  cnt_load_val          = MULDIV_LOAD;
                  state_d               = ST_MULDIV;
               end else if (branch_taken) begin
                  ctrl.clear[STG_FEDE]  = 1'b1;
                  ctrl.clear[STG_DEEX]  = 1'b1;
               end else if (load_use) begin
                  ctrl.hold_pc          = 1'b1;
                  ctrl.hold[STG_FEDE]   = 1'b1;
                  ctrl.clear[STG_DEEX]  = 1'b1;
               end else if (irq && !int_active_q) begin
                  cnt_load              = 1'b1;
                  cnt_load_val          = DRAIN_LOAD;
                  state_d               = ST_DRAIN;
               end
            end
            ST_MULDIV: begin
               // The zero-count cycle releases EX; ex_multicycle is still high for
               // the same op here, so it must not restart the sequence.
               if (cnt_zero) begin
                  state_d = ST_RUN;
               end else begin
                  ctrl.hold_pc          = 1'b1;
                  ctrl.hold[STG_FEDE]   = 1'b1;
                  ctrl.hold[STG_DEEX]   = 1'b1;
                  ctrl.clear[STG_EXMEM] = 1'b1;
                  cnt_dec               = 1'b1;
               end
            end
            ST_DRAIN: begin
               ctrl.hold_pc         = 1'b1;
               ctrl.clear[STG_FEDE] = 1'b1;
               cnt_dec              = 1'b1;
               if (cnt_val <= CNT_ONE) begin
                  state_d = ST_JUMP;
               end
            end
            ST_JUMP: begin
               ctrl.int_jump        = 1'b1;
               ctrl.clear[STG_FEDE] = 1'b1;
               int_active_d         = 1'b1;
               state_d              = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         int_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         int_active_q <= int_active_d;
      end
   end

   assign hold_pc     = ctrl.hold_pc;
   assign hold_fede   = ctrl.hold[STG_FEDE];
   assign hold_deex   = ctrl.hold[STG_DEEX];
   assign hold_exmem  = ctrl.hold[STG_EXMEM];
   assign hold_memwb  = ctrl.hold[STG_MEMWB];
   assign clear_fede  = ctrl.clear[STG_FEDE];
   assign clear_deex  = ctrl.clear[STG_DEEX];
   assign clear_exmem = ctrl.clear[STG_EXMEM];
   assign clear_memwb = ctrl.clear[STG_MEMWB];
   assign int_jump    = ctrl.int_jump;
   assign irq_ack     = ctrl.int_jump;
   assign int_active  = int_active_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

   localparam int MC = 4;
   localparam int DC = 3;

   // Stimulus vector bits: {reset, mem_busy, ex_multicycle, branch_taken, load_use, irq, reti}
   localparam logic [6:0] S_IDLE = 7'b0000000;
   localparam logic [6:0] S_RST  = 7'b1000000;
   localparam logic [6:0] S_BUSY = 7'b0100000;
   localparam logic [6:0] S_MUL  = 7'b0010000;
   localparam logic [6:0] S_BR   = 7'b0001000;
   localparam logic [6:0] S_LU   = 7'b0000100;
   localparam logic [6:0] S_IRQ  = 7'b0000010;
   localparam logic [6:0] S_RETI = 7'b0000001;

   // Observed/expected control vector bit positions
   localparam int B_HPC = 10, B_HFD = 9, B_HDE = 8, B_HEM = 7, B_HMW = 6;
   localparam int B_CFD = 5,  B_CDE = 4, B_CEM = 3, B_CMW = 2, B_JMP = 1, B_ACK = 0;

   logic clk = 1'b0;
   logic reset, mem_busy, ex_multicycle, branch_taken, load_use, irq, reti;
   logic hold_pc, hold_fede, hold_deex, hold_exmem, hold_memwb;
   logic clear_fede, clear_deex, clear_exmem, clear_memwb;
   logic int_jump, irq_ack, int_active;
   logic [10:0] obs_o;
   logic [10:0] last_obs;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: stall cycles already spent on the current multi-cycle op
   // (-1 = none), drain cycles already spent since irq acceptance (-1 = none).
   int m_mul    = -1;
   int m_drain  = -1;
   bit m_active = 1'b0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MULDIV_CYCLES(MC), .DRAIN_CYCLES(DC)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_busy      (mem_busy),
      .ex_multicycle (ex_multicycle),
      .branch_taken  (branch_taken),
      .load_use      (load_use),
      .irq           (irq),
      .reti          (reti),
      .hold_pc       (hold_pc),
      .hold_fede     (hold_fede),
      .hold_deex     (hold_deex),
      .hold_exmem    (hold_exmem),
      .hold_memwb    (hold_memwb),
      .clear_fede    (clear_fede),
      .clear_deex    (clear_deex),
      .clear_exmem   (clear_exmem),
      .clear_memwb   (clear_memwb),
      .int_jump      (int_jump),
      .irq_ack       (irq_ack),
      .int_active    (int_active)
   );

   assign obs_o = {hold_pc, hold_fede, hold_deex, hold_exmem, hold_memwb,
                   clear_fede, clear_deex, clear_exmem, clear_memwb, int_jump, irq_ack};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // Expected controls for this cycle's inputs, and the model state after the edge.
   task automatic model(input logic [6:0] s, output logic [10:0] e,
                        output int n_mul, output int n_drain, output bit n_act);
      bit r, mb, ex, br, lu, iq, rt;
      {r, mb, ex, br, lu, iq, rt} = s;
      e       = '0;
      n_mul   = m_mul;
      n_drain = m_drain;
      n_act   = rt ? 1'b0 : m_active;
      if (r) begin
         e[B_HPC] = 1'b1;
         e[B_CFD] = 1'b1; e[B_CDE] = 1'b1; e[B_CEM] = 1'b1; e[B_CMW] = 1'b1;
         n_mul = -1; n_drain = -1; n_act = 1'b0;
      end else if (mb) begin
         e[B_HPC] = 1'b1; e[B_HFD] = 1'b1; e[B_HDE] = 1'b1; e[B_HEM] = 1'b1;
         e[B_CMW] = 1'b1;
      end else if (m_mul >= 0) begin
         if (m_mul < MC) begin
            e[B_HPC] = 1'b1; e[B_HFD] = 1'b1; e[B_HDE] = 1'b1; e[B_CEM] = 1'b1;
            n_mul = m_mul + 1;
         end else begin
            n_mul = -1;
         end
      end else if (m_drain >= 0) begin
         if (m_drain < DC) begin
            e[B_HPC] = 1'b1; e[B_CFD] = 1'b1;
            n_drain = m_drain + 1;
         end else begin
            e[B_JMP] = 1'b1; e[B_ACK] = 1'b1; e[B_CFD] = 1'b1;
            n_drain = -1; n_act = 1'b1;
         end
      end else if (ex) begin
         e[B_HPC] = 1'b1; e[B_HFD] = 1'b1; e[B_HDE] = 1'b1; e[B_CEM] = 1'b1;
         n_mul = 1;
      end else if (br) begin
         e[B_CFD] = 1'b1; e[B_CDE] = 1'b1;
      end else if (lu) begin
         e[B_HPC] = 1'b1; e[B_HFD] = 1'b1; e[B_CDE] = 1'b1;
      end else if (iq && !m_active) begin
         n_drain = 0;
      end
   endtask

   task automatic step(input string tag, input logic [6:0] s);
      logic [10:0] e;
      int nm, nd;
      bit na;
      @(negedge clk);
      {reset, mem_busy, ex_multicycle, branch_taken, load_use, irq, reti} = s;
      #1;
      model(s, e, nm, nd, na);
      check({tag, " ctrl"}, 32'(obs_o), 32'(e));
      check({tag, " int_active"}, 32'(int_active), 32'(m_active));
      last_obs = obs_o;
      @(posedge clk);
      m_mul = nm; m_drain = nd; m_active = na;
   endtask

   // Steps with the given stimulus until int_jump is seen; returns the step count.
   task automatic run_to_jump(input string tag, input logic [6:0] s, input int limit,
                              output int cycles, output int n_hpc);
      cycles = 0;
      n_hpc  = 0;
      do begin
         cycles++;
         step(tag, s);
         if (!last_obs[B_JMP]) n_hpc += int'(last_obs[B_HPC]);
      end while (!last_obs[B_JMP] && cycles < limit);
   endtask

   initial begin
      int cyc, n_hpc, n_hde, n_cem, n_cmw;
      logic [6:0] mul_seq [6];
      logic [6:0] s;

      {reset, mem_busy, ex_multicycle, branch_taken, load_use, irq, reti} = S_RST;

      step("reset0", S_RST);
      step("reset1", S_RST);
      step("idle", S_IDLE);

      // Reset on the second stall cycle of a multi-cycle op
      step("mul_start", S_MUL);
      step("mul_reset", S_MUL | S_RST);
      check("mul_reset clears+hold_pc", 32'({last_obs[B_HPC], last_obs[B_CFD], last_obs[B_CDE],
                                             last_obs[B_CEM], last_obs[B_CMW]}), 32'h1f);
      step("post_reset", S_IDLE);
      check("post_reset no holds", 32'(last_obs[B_HPC:B_HMW]), 32'h0);

      // Multi-cycle op with one mem_busy cycle in the middle of the count
      mul_seq = '{S_MUL, S_MUL, S_MUL | S_BUSY, S_MUL, S_MUL, S_MUL};
      n_hde = 0; n_cem = 0;
      foreach (mul_seq[i]) begin
         step($sformatf("muldiv%0d", i), mul_seq[i]);
         n_hde += int'(last_obs[B_HDE]);
         n_cem += int'(last_obs[B_CEM]);
      end
      check("muldiv hold_deex cycles", 32'(n_hde), 32'(MC + 1));
      check("muldiv clear_exmem cycles", 32'(n_cem), 32'(MC));
      step("muldiv_after", S_IDLE);

      // Branch wins over a simultaneous load-use
      step("br_lu", S_BR | S_LU);
      check("br_lu pc/clears", 32'({last_obs[B_HPC], last_obs[B_CFD], last_obs[B_CDE]}), 32'b011);
      step("lu_only", S_LU);
      step("idle2", S_IDLE);

      // Interrupt entry with irq held high
      step("irq_accept", S_IRQ);
      run_to_jump("irq_drain", S_IRQ, 20, cyc, n_hpc);
      check("irq latency", 32'(cyc), 32'(DC + 1));
      check("irq hold_pc cycles", 32'(n_hpc), 32'(DC));
      step("irq_masked0", S_IRQ);
      check("int_jump single cycle", 32'(last_obs[B_JMP]), 32'h0);
      step("irq_masked1", S_IRQ);
      step("irq_reti", S_IRQ | S_RETI);
      step("irq_reaccept", S_IRQ);
      step("irq_redrain", S_IDLE);
      check("irq accepted after reti", 32'({last_obs[B_HPC], last_obs[B_CFD]}), 32'b11);
      run_to_jump("irq2_drain", S_IDLE, 20, cyc, n_hpc);
      check("irq2 remaining latency", 32'(cyc), 32'(DC));
      step("irq2_reti", S_RETI);

      // irq together with load_use: bubble first, acceptance one cycle later
      step("irq_lu", S_IRQ | S_LU);
      check("irq_lu bubble", 32'({last_obs[B_HPC], last_obs[B_HFD], last_obs[B_CDE]}), 32'b111);
      step("irq_lu_accept", S_IRQ);
      run_to_jump("irq_lu_drain", S_IDLE, 20, cyc, n_hpc);
      check("irq_lu latency", 32'(cyc), 32'(DC + 1));
      step("irq_lu_reti", S_RETI);

      // mem_busy held 5 cycles inside DRAIN
      step("busy_accept", S_IRQ);
      cyc = 0; n_cmw = 0;
      do begin
         cyc++;
         s = (cyc >= 2 && cyc <= 6) ? S_BUSY : S_IDLE;
         step($sformatf("busy_drain%0d", cyc), s);
         if (s == S_BUSY) n_cmw += int'(last_obs[B_CMW]);
      end while (!last_obs[B_JMP] && cyc < 30);
      check("busy drain latency", 32'(cyc), 32'(DC + 1 + 5));
      check("busy clear_memwb cycles", 32'(n_cmw), 32'd5);
      step("busy_reti", S_RETI);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit ex;
         ex = ($urandom % 8) == 0;
         s = {($urandom % 97) == 0, ($urandom % 5) == 0, ex,
              !ex && (($urandom % 6) == 0), ($urandom % 5) == 0,
              ($urandom % 4) == 0, ($urandom % 16) == 0};
         step($sformatf("rand%0d", i), s);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
